// File: rtl/bitrev_reorder_if.sv
// Stream interface for bitrev_reorder: natural-order input side and
// bit-reversed output side. out_last exists only when BITREV_LAST_EN is defined.
interface bitrev_reorder_if #(
  parameter int LOGN = 3,
  parameter int W    = 16
) ();
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [LOGN-1:0] out_index;
`ifdef BITREV_LAST_EN
  logic            out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index
  );
`endif
endinterface

// File: rtl/bitrev_reorder.sv
// bitrev_reorder: ping-pong frame buffer converting N = 2^LOGN samples from
// natural order to bit-reversed order, one sample per clock in steady state.
// Optional feature macro: BITREV_LAST_EN adds out_last (last sample of frame).
module bitrev_reorder #(
  parameter int LOGN = 3,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  bitrev_reorder_if.slave   bus
);
  localparam int N = 1 << LOGN;

  typedef logic [LOGN-1:0] cnt_t;
  typedef logic [LOGN:0]   addr_t;

  localparam cnt_t CNT_LAST = cnt_t'(N - 1);

  // Reverse the bit order of a frame index.
  function automatic cnt_t bitrev(input cnt_t k);
    cnt_t r;
    r = {<<{k}};
    return r;
  endfunction

  logic       wr_bank;
  logic       rd_bank;
  cnt_t       wr_cnt;
  cnt_t       rd_cnt;
  logic [1:0] full;

  logic [W-1:0] mem [2*N];

  logic  wr_fire;
  logic  rd_fire;
  logic  wr_wrap;
  logic  rd_wrap;
  logic  rd_avail;
  cnt_t  rd_rev;
  addr_t wr_addr;
  addr_t rd_addr;

  // Handshake decode and bank/slot address generation.
  always_comb begin
    rd_avail = full[rd_bank];
    rd_rev   = bitrev(rd_cnt);
    wr_fire  = bus.in_valid && !full[wr_bank];
    rd_fire  = rd_avail && bus.out_ready;
    wr_wrap  = wr_fire && (wr_cnt == CNT_LAST);
    rd_wrap  = rd_fire && (rd_cnt == CNT_LAST);
    wr_addr  = {wr_bank, wr_cnt};
    rd_addr  = {rd_bank, rd_rev};
  end

  // Output side: combinational read from storage so there is no bubble.
  always_comb begin
    bus.in_ready  = !full[wr_bank];
    bus.out_valid = rd_avail;
    bus.out_index = rd_rev;
    bus.out_data  = rd_avail ? mem[rd_addr] : '0;
  end

`ifdef BITREV_LAST_EN
  // Flag the final output sample of each frame.
  always_comb begin
    bus.out_last = rd_avail && (rd_cnt == CNT_LAST);
  end
`endif

  // Sample storage; contents are never reset and only read once a bank is full.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= bus.in_data;
    end
  end

  // Write pointer: slot counter and bank select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + cnt_t'(1);
      if (wr_wrap) begin
        wr_bank <= !wr_bank;
      end
    end
  end

  // Read pointer: slot counter and bank select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      rd_cnt <= rd_cnt + cnt_t'(1);
      if (rd_wrap) begin
        rd_bank <= !rd_bank;
      end
    end
  end

  // Bank full flags. A completing write targets an empty bank and a completing
  // read targets a full one, so both updates can land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (wr_wrap) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_wrap) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Self-checking bench for bitrev_reorder (LOGN = 3, W = 16).
module tb_bitrev_reorder;
  localparam int LOGN = 3;
  localparam int W    = 16;
  localparam int N    = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bitrev_reorder_if #(.LOGN(LOGN), .W(W)) bus ();

  bitrev_reorder #(.LOGN(LOGN), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Bit reversal by arithmetic: read bits of k LSB-first, build result MSB-first.
  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < LOGN; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  // Reference model: partial input frame plus queue of pending outputs.
  typedef struct {
    logic [W-1:0] d;
    int           idx;
  } ent_t;

  logic [W-1:0] part[$];
  ent_t         expq[$];

  logic [W-1:0] got_d[$];
  int           got_cyc[$];
  int           cyc;
  logic         prev_stall;
  logic [W-1:0] prev_d;
  logic [31:0]  prev_i;

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy, output logic acc);
    int   nfull;
    logic m_rdy, m_val, rd;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;
    nfull = (expq.size() + N - 1) / N;
    m_rdy = (nfull < 2);
    m_val = (nfull > 0);
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_val));
    if (m_val) begin
      chk("out_data", 32'(bus.out_data), 32'(expq[0].d));
      chk("out_index", 32'(bus.out_index), expq[0].idx);
    end else begin
      chk("out_data_idle", 32'(bus.out_data), 32'd0);
    end
`ifdef BITREV_LAST_EN
    chk("out_last", 32'(bus.out_last), 32'(m_val && expq[0].idx == N - 1));
`endif
    if (prev_stall) begin
      chk("stall_data", 32'(bus.out_data), 32'(prev_d));
      chk("stall_index", 32'(bus.out_index), prev_i);
    end
    prev_stall = bus.out_valid && !ordy;
    prev_d     = bus.out_data;
    prev_i     = 32'(bus.out_index);
    acc = iv && m_rdy;
    rd  = m_val && ordy;
    if (rd) begin
      got_d.push_back(bus.out_data);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (rd) void'(expq.pop_front());
    if (acc) begin
      part.push_back(id);
      if (part.size() == N) begin
        for (int k = 0; k < N; k++) expq.push_back('{part[brev(k)], brev(k)});
        part.delete();
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Assert reset at a falling edge, check reset values at once, then release.
  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_index", 32'(bus.out_index), 32'd0);
`ifdef BITREV_LAST_EN
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
`endif
    part.delete();
    expq.delete();
    got_d.delete();
    got_cyc.delete();
    prev_stall = 1'b0;
    cyc = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         e_rdy;
    logic         e_val;
    logic [W-1:0] e_d;
    logic [31:0]  e_idx;
    logic         e_last;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic         acc;
    int           nacc;
    int           first_acc;
    int           order[8];
    int           rst_exp[8];
    logic [W-1:0] sent[$];

    order   = '{0, 4, 2, 6, 1, 5, 3, 7};
    rst_exp = '{10, 14, 12, 16, 11, 15, 13, 17};
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, W'(i), 1'b1, 1'b1, 1'b0, '0, 32'd0, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[8 + i] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, W'(order[i]), 32'(order[i]), (i == 7)};
    tbl[16] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 32'd0, 1'b0};

    rst_n = 1'b1;
    prev_stall = 1'b0;
    cyc = 0;
    @(negedge clk);
    do_reset();

    // Single frame, table-driven.
    for (int r = 0; r < 17; r++) begin
      bus.in_valid  = tbl[r].iv;
      bus.in_data   = tbl[r].id;
      bus.out_ready = tbl[r].ordy;
      #1;
      chk("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[r].e_rdy));
      chk("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[r].e_val));
      chk("tbl_out_data", 32'(bus.out_data), 32'(tbl[r].e_d));
      chk("tbl_out_index", 32'(bus.out_index), tbl[r].e_idx);
`ifdef BITREV_LAST_EN
      chk("tbl_out_last", 32'(bus.out_last), 32'(tbl[r].e_last));
`endif
      @(posedge clk);
      @(negedge clk);
    end

    // Back-to-back frames.
    do_reset();
    nacc = 0;
    for (int c = 0; c < 24; c++) begin
      cycle(1'b1, W'(nacc), 1'b1, acc);
      if (acc) nacc++;
    end
    chk("b2b_accepts", nacc, 24);
    for (int c = 0; c < 40 && got_d.size() < 24; c++) cycle(1'b0, '0, 1'b1, acc);
    chk("b2b_count", got_d.size(), 24);
    if (got_d.size() == 24) begin
      chk("b2b_first_cyc", got_cyc[0], 8);
      chk("b2b_contiguous", got_cyc[23] - got_cyc[0], 23);
      for (int i = 0; i < 24; i++)
        chk("b2b_seq", 32'(got_d[i]), (i / 8) * 8 + brev(i % 8));
    end

    // Backpressure.
    do_reset();
    nacc = 0;
    for (int c = 0; c < 40 && nacc < 16; c++) begin
      cycle(1'b1, W'(nacc), 1'b0, acc);
      if (acc) nacc++;
    end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, W'(nacc), 1'b0, acc);
      if (acc) nacc++;
    end
    chk("bp_stalled_accepts", nacc, 16);
    first_acc = -1;
    for (int c = 0; c < 100 && (nacc < 20 || got_d.size() < 16); c++) begin
      int cnow;
      cnow = cyc;
      cycle(nacc < 20, W'(nacc), 1'b1, acc);
      if (acc) begin
        if (first_acc < 0) first_acc = cnow;
        nacc++;
      end
    end
    chk("bp_total_accepts", nacc, 20);
    chk("bp_outputs", got_d.size(), 16);
    if (got_d.size() >= 8) begin
      chk("bp_ready_recover", first_acc, got_cyc[7] + 1);
      for (int i = 0; i < 8; i++) chk("bp_frame0", 32'(got_d[i]), brev(i));
    end

    // Reset mid-frame, with an unread frame pending.
    do_reset();
    for (int i = 0; i < 13; i++) cycle(1'b1, W'(100 + i), 1'b0, acc);
    chk("mid_valid_before", 32'(bus.out_valid), 32'd1);
    do_reset();
    nacc = 0;
    for (int c = 0; c < 40 && got_d.size() < 8; c++) begin
      cycle(nacc < 8, W'(10 + nacc), 1'b1, acc);
      if (acc) nacc++;
    end
    chk("mid_count", got_d.size(), 8);
    if (got_d.size() == 8)
      for (int i = 0; i < 8; i++) chk("mid_seq", 32'(got_d[i]), rst_exp[i]);

    // Random bubbles on both sides over 10 frames.
    do_reset();
    nacc = 0;
    for (int c = 0; c < 3000 && got_d.size() < 80; c++) begin
      logic         iv;
      logic [W-1:0] d;
      iv = (nacc < 80) && ($urandom % 2 == 0);
      d  = W'($urandom);
      cycle(iv, d, 1'($urandom % 3 != 0), acc);
      if (acc) begin
        sent.push_back(d);
        nacc++;
      end
    end
    chk("rnd_count", got_d.size(), 80);
    if (got_d.size() == 80 && sent.size() == 80)
      for (int i = 0; i < 80; i++)
        chk("rnd_seq", 32'(got_d[i]), 32'(sent[(i / 8) * 8 + brev(i % 8)]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitrev_reorder.md
# bitrev_reorder

Streaming ping-pong reorder buffer that converts a frame of N = 2^LOGN samples from natural order to bit-reversed index order. It sits between the sample source and the radix-2 FFT, which consumes bit-reversed input. Frame storage, full/empty tracking and the valid/ready handshakes on both sides are contained here, and throughput is one sample per clock in steady state.

## Interface
- LOGN, default 3: log2 of the frame length. N = 2^LOGN samples per frame.
- W, default 16: sample width in bits. A complex sample is packed as {re, im} by the producer.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  W  sample in natural order.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  W  sample in bit-reversed order.
- out_index  out  LOGN  natural input index of the sample currently presented.
- out_last  out  1  marks the last sample of a frame. Present only with BITREV_LAST_EN; see Configuration.

## Operation
- Storage: two banks of N words each. State:
  - wr_bank and rd_bank, 1 bit each.
  - wr_cnt and rd_cnt, LOGN bits each.
  - full[1:0].
- bitrev(k) is defined bitwise: bitrev(k)[i] = k[LOGN-1-i].
- Write side:
  - A write is accepted when in_valid && in_ready.
  - in_ready = !full[wr_bank].
  - An accepted sample is written to bank[wr_bank][wr_cnt], then wr_cnt increments.
  - On the accept with wr_cnt == N-1: set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
- Read side:
  - out_valid = full[rd_bank].
  - out_index = bitrev(rd_cnt).
  - out_data = bank[rd_bank][bitrev(rd_cnt)] when out_valid, otherwise 0. The read is combinational from storage, so there is no output bubble.
  - A read is accepted when out_valid && out_ready, then rd_cnt increments.
  - On the accept with rd_cnt == N-1: clear full[rd_bank], toggle rd_bank, and wrap rd_cnt to 0.
- Simultaneous write completion and read completion in one cycle: both flag updates take effect. One bank's full flag is set and the other's is cleared in the same edge.
- Full state: both banks full gives in_ready = 0. in_ready recovers the cycle after a read frame completes.
- Empty state: no bank full gives out_valid = 0. Writes continue.
- out_data and out_index are stable while out_valid && !out_ready.
- Reset mid-frame:
  - All counters, bank pointers and full flags clear.
  - Partial input frames and unread frames are discarded.
  - Storage contents are not reset and are never observed.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_data = 0
  - out_index = 0
  - out_last = 0
- Latency: the first sample of a frame appears with out_valid = 1 in the cycle after the frame's Nth input accept.
- Steady state: with in_valid = 1 and out_ready = 1 continuously, in_ready never deasserts after reset. Output is continuous from cycle N onward, counting from the first accept at cycle 0.
- Storage writes happen on the clock edge. A sample written in cycle t is readable from cycle t+1.

## Configuration
- BITREV_LAST_EN defined:
  - Adds the out_last port.
  - out_last = out_valid && (rd_cnt == N-1).
  - out_last resets to 0.
- BITREV_LAST_EN undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use LOGN = 3 and W = 16.
- Single frame: in_data = 0..7 on consecutive cycles, out_ready = 1. Required response:
  - out_data = 0,4,2,6,1,5,3,7.
  - out_index matches out_data.
  - First out_valid appears one cycle after the 8th accept.
- Back-to-back frames: three frames with in_data = f*8+k, in_valid and out_ready held at 1. Required response:
  - in_ready stays at 1 throughout.
  - 24 outputs appear on consecutive cycles in bit-reversed order within each frame.
- Backpressure: out_ready = 0 while feeding 20 samples. Required response:
  - in_ready drops to 0 after the 16th accept.
  - Raising out_ready drains frame 0 first.
  - in_ready returns to 1 the cycle after the 8th read.
  - The remaining 4 samples are then accepted.
- Reset mid-frame: assert rst_n low after 5 accepts. Required response:
  - out_valid = 0 and in_ready = 1 immediately.
  - The next 8 inputs 10..17 produce 10,14,12,16,11,15,13,17.
- Bubbles on both sides: in_valid and out_ready toggled pseudo-randomly over 10 frames. Required response:
  - Output sequence equals the reference bitrev model.
  - out_data and out_index are stable whenever out_valid && !out_ready.
- With BITREV_LAST_EN: run the single-frame stimulus. Required response:
  - out_last = 1 only on the output with out_index = 7.
  - out_last = 0 after reset.
